lcd_reader: RTL



---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_reader_if.sv | 29 ++
 rtl/lcd_rd_timer.sv | 27 ++
 rtl/lcd_reader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 reader and writer.
//   - rd_state_t : read-engine FSM states
//   - RS_CMD / RS_DATA : register-select encodings
//   - 100 MHz timing constants shared with the init/write sequencer
//   - max4 : helper used to size counters from the timing parameters
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EN_HI_U,
      GAP_U,
      EN_HI_L,
      GAP_L,
      CHECK
   } rd_state_t;

   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_DATA = 1'b1;

   // Clock-cycle counts at 100 MHz (10 ns per cycle).
   localparam int unsigned U400 = 40;          // 400 ns
   localparam int unsigned U40  = 4_000;       // 40 us
   localparam int unsigned U100 = 10_000;      // 100 us
   localparam int unsigned M1   = 100_000;     // 1 ms
   localparam int unsigned M5   = 500_000;     // 5 ms
   localparam int unsigned M15  = 1_500_000;   // 15 ms

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// lcd_reader_if: host handshake plus LCD pin bundle for the read engine.
//   Host side : req, rs_sel, poll -> busy, done, rd_data, timeout
//   LCD side  : lcd_db_in (D7..D4) -> lcd_rs, lcd_rw, lcd_en, rd_active
//   modport slave  : the reader itself
//   modport master : whoever issues requests and presents the LCD data pins
interface lcd_reader_if;
   logic       req;
   logic       rs_sel;
   logic       poll;
   logic [3:0] lcd_db_in;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;
   logic       rd_active;
   logic       busy;
   logic       done;
   logic [7:0] rd_data;
   logic       timeout;

   modport slave (
      input  req, rs_sel, poll, lcd_db_in,
      output lcd_rs, lcd_rw, lcd_en, rd_active, busy, done, rd_data, timeout
   );

   modport master (
      output req, rs_sel, poll, lcd_db_in,
      input  lcd_rs, lcd_rw, lcd_en, rd_active, busy, done, rd_data, timeout
   );
endinterface

// File: rtl/lcd_rd_timer.sv
// lcd_rd_timer: loadable down-counter for the read FSM phase timing.
//   clk, rst  : clock, async active-high reset
//   load      : reload with load_val (asserted on every state entry)
//   load_val  : phase length minus one
//   expired   : high while the count sits at zero; the FSM leaves the state
//               on it, so within a phase it behaves as a terminal pulse
module lcd_rd_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             expired
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)             cnt <= '0;
      else if (load)       cnt <= load_val;
      else if (cnt != '0)  cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: 4-bit HD44780 read engine (RW=1 cycles).
//   clk, rst : 100 MHz clock, async active-high reset
//   bus      : lcd_reader_if.slave
//     req/rs_sel/poll   start a BF/AC read (rs_sel=0) or data read (rs_sel=1);
//                       poll repeats BF/AC reads while BF=1, up to POLL_MAX reads
//     lcd_db_in         D7..D4 from the panel
//     lcd_rs/rw/en      panel control; rd_active marks bus ownership
//     busy/done         request in progress / one-cycle completion
//     rd_data/timeout   last byte read / poll limit hit with BF still set
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int unsigned T_AS     = 4,
   parameter int unsigned T_PW     = 50,
   parameter int unsigned T_GAP    = 100,
   parameter int unsigned POLL_MAX = 1000
) (
   input  logic         clk,
   input  logic         rst,
   lcd_reader_if.slave  bus
);

   localparam int unsigned CMAX = max4(T_AS, T_PW, T_GAP, POLL_MAX);
   localparam int unsigned CW   = $clog2(CMAX + 1);
   typedef logic [CW-1:0] cnt_t;

   // Timer reloads are length-1 so a phase lasts exactly its parameter.
   localparam cnt_t LD_AS     = cnt_t'(T_AS - 1);
   localparam cnt_t LD_PW     = cnt_t'(T_PW - 1);
   localparam cnt_t LD_GAP    = cnt_t'(T_GAP - 1);
   localparam cnt_t POLL_LAST = cnt_t'(POLL_MAX - 1);

   rd_state_t  state, state_nx;
   logic       poll_q, poll_nx;
   cnt_t       pcnt, pcnt_nx;
   logic [7:0] byte_q, byte_nx;

   // Registered outputs. The latched rs_sel lives directly in rs_o.
   logic       rs_o, rs_nx;
   logic       rw_o, rw_nx;
   logic       en_o, en_nx;
   logic       act_o, act_nx;
   logic       busy_o, busy_nx;
   logic       done_o, done_nx;
   logic [7:0] data_o, data_nx;
   logic       to_o, to_nx;

   logic       t_load;
   cnt_t       t_val;
   logic       t_exp;

   lcd_rd_timer #(.WIDTH(CW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (t_load),
      .load_val (t_val),
      .expired  (t_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         poll_q <= 1'b0;
         pcnt   <= '0;
         byte_q <= 8'h00;
         rs_o   <= 1'b0;
         rw_o   <= 1'b0;
         en_o   <= 1'b0;
         act_o  <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         data_o <= 8'h00;
         to_o   <= 1'b0;
      end else begin
         state  <= state_nx;
         poll_q <= poll_nx;
         pcnt   <= pcnt_nx;
         byte_q <= byte_nx;
         rs_o   <= rs_nx;
         rw_o   <= rw_nx;
         en_o   <= en_nx;
         act_o  <= act_nx;
         busy_o <= busy_nx;
         done_o <= done_nx;
         data_o <= data_nx;
         to_o   <= to_nx;
      end
   end

   always_comb begin
      state_nx = state;
      poll_nx  = poll_q;
      pcnt_nx  = pcnt;
      byte_nx  = byte_q;
      rs_nx    = rs_o;
      rw_nx    = rw_o;
      en_nx    = en_o;
      act_nx   = act_o;
      busy_nx  = busy_o;
      done_nx  = 1'b0;
      data_nx  = data_o;
      to_nx    = to_o;
      t_load   = 1'b0;
      t_val    = '0;

      unique case (state)
         IDLE: begin
            if (bus.req) begin
               poll_nx  = bus.poll & ~bus.rs_sel;
               pcnt_nx  = '0;
               to_nx    = 1'b0;
               rs_nx    = bus.rs_sel;
               rw_nx    = 1'b1;
               act_nx   = 1'b1;
               busy_nx  = 1'b1;
               t_load   = 1'b1;
               t_val    = LD_AS;
               state_nx = SETUP;
            end
         end
         SETUP: begin
            if (t_exp) begin
               en_nx    = 1'b1;
               t_load   = 1'b1;
               t_val    = LD_PW;
               state_nx = EN_HI_U;
            end
         end
         EN_HI_U: begin
            // Sample on the falling edge of E, while the panel still drives.
            if (t_exp) begin
               en_nx        = 1'b0;
               byte_nx[7:4] = bus.lcd_db_in;
               t_load       = 1'b1;
               t_val        = LD_GAP;
               state_nx     = GAP_U;
            end
         end
         GAP_U: begin
            if (t_exp) begin
               en_nx    = 1'b1;
               t_load   = 1'b1;
               t_val    = LD_PW;
               state_nx = EN_HI_L;
            end
         end
         EN_HI_L: begin
            if (t_exp) begin
               en_nx        = 1'b0;
               byte_nx[3:0] = bus.lcd_db_in;
               t_load       = 1'b1;
               t_val        = LD_GAP;
               state_nx     = GAP_L;
            end
         end
         GAP_L: begin
            if (t_exp) state_nx = CHECK;
         end
         CHECK: begin
            if (poll_q && byte_q[7] && (pcnt < POLL_LAST)) begin
               // RS/RW stay put, so SETUP again guarantees address setup.
               pcnt_nx  = pcnt + 1'b1;
               t_load   = 1'b1;
               t_val    = LD_AS;
               state_nx = SETUP;
            end else begin
               data_nx  = byte_q;
               to_nx    = poll_q & byte_q[7];
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               act_nx   = 1'b0;
               rw_nx    = 1'b0;
               rs_nx    = RS_CMD;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.lcd_rs    = rs_o;
   assign bus.lcd_rw    = rw_o;
   assign bus.lcd_en    = en_o;
   assign bus.rd_active = act_o;
   assign bus.busy      = busy_o;
   assign bus.done      = done_o;
   assign bus.rd_data   = data_o;
   assign bus.timeout   = to_o;

endmodule
